porttest_arbiter: RTL and testbench
===================================

// Module: porttest_arbiter
// PURPOSE
//  Downstream of two porttest stress generators: merges two toggle-handshake client ports
//  (rd/wr req/ack) onto one SDRAM-controller port of the same protocol.
//  One transaction in flight at a time; read data is returned to the issuing client.
//  Lets two independent LFSR testers share one controller port, adding arbitration stress.
// PARAMETERS
//  addrwidth  16  word address width; address bus is [addrwidth:1]
//  datawidth  16  data bus width
// PORTS
//  clk         in   1          clock
//  reset_n     in   1          async active-low reset
//  cN_a        in   addrwidth  client N address, N=0,1; stable while request pending
//  cN_q        in   datawidth  client N write data
//  cN_we       in   1          client N write enable (informational, not used for decode)
//  cN_rd_req   in   1          client N read toggle; pending when cN_rd_req!=cN_rd_ack
//  cN_wr_req   in   1          client N write toggle; pending when cN_wr_req!=cN_wr_ack
//  cN_rd_ack   out  1          toggled to equal cN_rd_req on read completion
//  cN_wr_ack   out  1          toggled to equal cN_wr_req on write completion
//  cN_d        out  datawidth  last read data for client N; valid when ack==req
//  m_a         out  addrwidth  controller address
//  m_q         out  datawidth  controller write data
//  m_we        out  1          1 for write transaction, 0 for read
//  m_rd_req    out  1          controller read toggle
//  m_wr_req    out  1          controller write toggle
//  m_rd_ack    in   1          controller read ack toggle
//  m_wr_ack    in   1          controller write ack toggle
//  m_d         in   datawidth  controller read data, valid when m_rd_ack==m_rd_req
// BEHAVIOUR
//  Reset: all outputs 0 (acks, reqs, a, q, we, d); rr pointer=0; state=SYNC.
//  States: SYNC, IDLE, WAIT.
//  SYNC: hold until m_rd_ack==m_rd_req and m_wr_ack==m_wr_req (controller may not have been
//   reset with us); then IDLE. No requests issued in SYNC. Reset mid-transaction abandons it;
//   client acks return to 0 and clients re-sync as in their INIT.
//  IDLE: pending set = {c0 rd/wr, c1 rd/wr}. If empty stay. Else select client: round-robin,
//   rr pointer names preferred client; other client only if preferred has nothing pending.
//   Within a client, write before read if both pending. Same edge: register m_a, m_q, m_we,
//   toggle m_wr_req or m_rd_req, record owner+kind, go WAIT. Latency pending->m toggle: 1 clk.
//  WAIT: on m_*_ack==m_*_req for recorded kind: toggle owner's matching ack; for read, load
//   owner's cN_d from m_d on the same edge; rr pointer = other client; go IDLE.
//   Completion->client ack visible: 1 clk. Min turnaround per transaction: 2 clk + controller.
//  Client requests arriving during WAIT are held pending (toggle level), never lost.
//  Client toggling again before its ack (protocol violation): undefined, no recovery needed.
//  Non-owner cN_d never changes. m_a/m_q/m_we hold value between transactions.
//  Simultaneous pending from both clients in same cycle: exactly one granted, by rr pointer.
// CONFIGURATION
//  PORTTEST_ARB_FIXEDPRI_EN defined: client 0 strict priority; rr pointer ignored (c1 may
//   starve). Undefined (default): round-robin as above; max wait = one other-client txn.
// TESTING
//  Reset with model acks m_rd_ack=m_wr_ack=1, m_rd_req=0 -> stays SYNC, no m toggle; model
//   re-syncs acks to 0 -> IDLE next clk.
//  c0 write a=0x0123 q=0xBEEF -> m_wr_req toggles 1 clk later, m_a=0x0123 m_q=0xBEEF m_we=1;
//   model acks after 3 clk -> c0_wr_ack==c0_wr_req 1 clk later; c1 ack unchanged.
//  c1 read a=0x0123, model m_d=0xBEEF -> c1_d=0xBEEF same edge c1_rd_ack toggles; c0_d stays 0.
//  c0 and c1 reads pending same cycle, rr=0 -> c0 served first, then c1; repeat with rr=1 ->
//   c1 first. With PORTTEST_ARB_FIXEDPRI_EN c0 always first.
//  Two porttest instances, cyclewidth 6, behavioural SDRAM model random 0-7 clk ack delay,
//   disjoint address halves, 100k reads -> errorcount=0 on both, both readcounts advance.
//  Assert reset_n during WAIT -> outputs 0 async; after release SYNC waits for stale ack.

Source files
------------

// File: rtl/porttest_arbiter.sv
// porttest_arbiter: merges two toggle-handshake porttest clients onto one controller port.
// Define PORTTEST_ARB_FIXEDPRI_EN for strict client-0 priority instead of round-robin.
module porttest_arbiter #(
   parameter int addrwidth = 16,
   parameter int datawidth = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [addrwidth:1]   c0_a,
   input  logic [datawidth-1:0] c0_q,
   input  logic                 c0_we,
   input  logic                 c0_rd_req,
   input  logic                 c0_wr_req,
   output logic                 c0_rd_ack,
   output logic                 c0_wr_ack,
   output logic [datawidth-1:0] c0_d,
   input  logic [addrwidth:1]   c1_a,
   input  logic [datawidth-1:0] c1_q,
   input  logic                 c1_we,
   input  logic                 c1_rd_req,
   input  logic                 c1_wr_req,
   output logic                 c1_rd_ack,
   output logic                 c1_wr_ack,
   output logic [datawidth-1:0] c1_d,
   output logic [addrwidth:1]   m_a,
   output logic [datawidth-1:0] m_q,
   output logic                 m_we,
   output logic                 m_rd_req,
   output logic                 m_wr_req,
   input  logic                 m_rd_ack,
   input  logic                 m_wr_ack,
   input  logic [datawidth-1:0] m_d
);

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      WAIT
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       rr;
   logic       owner;
   logic       kind_wr;
   logic       pref;
   logic [1:0] rd_pend;
   logic [1:0] wr_pend;
   logic [1:0] any_pend;
   logic       grant;
   logic       sel;
   logic       sel_wr;
   logic       done;
   logic       unused_we;

   assign unused_we = c0_we ^ c1_we;

   assign rd_pend  = {c1_rd_req ^ c1_rd_ack, c0_rd_req ^ c0_rd_ack};
   assign wr_pend  = {c1_wr_req ^ c1_wr_ack, c0_wr_req ^ c0_wr_ack};
   assign any_pend = rd_pend | wr_pend;

`ifdef PORTTEST_ARB_FIXEDPRI_EN
   assign pref = 1'b0;
`else
   assign pref = rr;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      sel       = pref;
      sel_wr    = 1'b0;
      done      = 1'b0;
      unique case (state)
         SYNC: begin
            // controller may still owe an ack from before our reset
            if (m_rd_ack == m_rd_req && m_wr_ack == m_wr_req)
               state_nxt = IDLE;
         end
         IDLE: begin
            if (|any_pend) begin
               grant     = 1'b1;
               sel       = any_pend[pref] ? pref : ~pref;
               sel_wr    = wr_pend[sel];
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            done = kind_wr ? (m_wr_ack == m_wr_req)
                           : (m_rd_ack == m_rd_req);
            if (done)
               state_nxt = IDLE;
         end
         default: state_nxt = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr        <= 1'b0;
         owner     <= 1'b0;
         kind_wr   <= 1'b0;
         m_a       <= '0;
         m_q       <= '0;
         m_we      <= 1'b0;
         m_rd_req  <= 1'b0;
         m_wr_req  <= 1'b0;
         c0_rd_ack <= 1'b0;
         c0_wr_ack <= 1'b0;
         c1_rd_ack <= 1'b0;
         c1_wr_ack <= 1'b0;
         c0_d      <= '0;
         c1_d      <= '0;
      end else begin
         if (grant) begin
            m_a     <= sel ? c1_a : c0_a;
            m_q     <= sel ? c1_q : c0_q;
            m_we    <= sel_wr;
            owner   <= sel;
            kind_wr <= sel_wr;
            if (sel_wr)
               m_wr_req <= ~m_wr_req;
            else
               m_rd_req <= ~m_rd_req;
         end
         if (done) begin
            rr <= ~owner;
            unique case ({owner, kind_wr})
               2'b00: begin
                  c0_rd_ack <= ~c0_rd_ack;
                  c0_d      <= m_d;
               end
               2'b01: c0_wr_ack <= ~c0_wr_ack;
               2'b10: begin
                  c1_rd_ack <= ~c1_rd_ack;
                  c1_d      <= m_d;
               end
               2'b11: c1_wr_ack <= ~c1_wr_ack;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_porttest_arbiter.sv
// tb_porttest_arbiter: directed and random two-client traffic against a
// random-latency controller, with a transaction-level model checked every cycle.
`timescale 1ns/1ps
module tb_porttest_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW:1]   c_a [2];
   logic [DW-1:0] c_q [2];
   logic [1:0]    c_we;
   logic [1:0]    c_rd_req;
   logic [1:0]    c_wr_req;
   logic          c0_rd_ack, c0_wr_ack, c1_rd_ack, c1_wr_ack;
   logic [DW-1:0] c0_d, c1_d;
   logic [AW:1]   m_a;
   logic [DW-1:0] m_q, m_d;
   logic          m_we, m_rd_req, m_wr_req, m_rd_ack, m_wr_ack;

   porttest_arbiter #(.addrwidth(AW), .datawidth(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .c0_a(c_a[0]), .c0_q(c_q[0]), .c0_we(c_we[0]),
      .c0_rd_req(c_rd_req[0]), .c0_wr_req(c_wr_req[0]),
      .c0_rd_ack(c0_rd_ack), .c0_wr_ack(c0_wr_ack), .c0_d(c0_d),
      .c1_a(c_a[1]), .c1_q(c_q[1]), .c1_we(c_we[1]),
      .c1_rd_req(c_rd_req[1]), .c1_wr_req(c_wr_req[1]),
      .c1_rd_ack(c1_rd_ack), .c1_wr_ack(c1_wr_ack), .c1_d(c1_d),
      .m_a(m_a), .m_q(m_q), .m_we(m_we),
      .m_rd_req(m_rd_req), .m_wr_req(m_wr_req),
      .m_rd_ack(m_rd_ack), .m_wr_ack(m_wr_ack), .m_d(m_d)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // reference model: transaction-level view of the arbiter
   bit            r_sync, r_busy, r_own, r_kw, r_rr;
   int            r_done [2];
   logic [AW:1]   e_ma;
   logic [DW-1:0] e_mq;
   logic          e_mwe, e_mrd, e_mwr;
   logic [1:0]    e_rack, e_wack;
   logic [DW-1:0] e_d [2];

   // controller model state
   bit auto_ctl, auto_cli;
   bit k_busy, k_wr;
   int k_cnt;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      r_sync = 0; r_busy = 0; r_own = 0; r_kw = 0; r_rr = 0;
      e_ma = '0; e_mq = '0; e_mwe = 0; e_mrd = 0; e_mwr = 0;
      e_rack = '0; e_wack = '0; e_d[0] = '0; e_d[1] = '0;
   endtask

   // advance the model across the posedge that just happened
   task automatic model_step();
      logic [1:0] pr, pw;
      bit pick;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (!r_sync) begin
         if (m_rd_ack == e_mrd && m_wr_ack == e_mwr) r_sync = 1;
      end else if (!r_busy) begin
         pr = c_rd_req ^ e_rack;
         pw = c_wr_req ^ e_wack;
`ifdef PORTTEST_ARB_FIXEDPRI_EN
         pick = (pr[0] | pw[0]) ? 1'b0 : 1'b1;
`else
         pick = (pr[r_rr] | pw[r_rr]) ? r_rr : !r_rr;
`endif
         if (pr[pick] | pw[pick]) begin
            r_own = pick;
            r_kw = pw[pick];
            e_ma = c_a[pick];
            e_mq = c_q[pick];
            e_mwe = r_kw;
            if (r_kw) e_mwr = ~e_mwr;
            else e_mrd = ~e_mrd;
            r_busy = 1;
         end
      end else if (r_kw ? (m_wr_ack == e_mwr) : (m_rd_ack == e_mrd)) begin
         if (r_kw) e_wack[r_own] = ~e_wack[r_own];
         else begin
            e_rack[r_own] = ~e_rack[r_own];
            e_d[r_own] = m_d;
         end
         r_done[r_own]++;
         r_rr = !r_own;
         r_busy = 0;
      end
   endtask

   task automatic compare_all();
      check("m_a", 32'(m_a), 32'(e_ma));
      check("m_q", 32'(m_q), 32'(e_mq));
      check("m_we", 32'(m_we), 32'(e_mwe));
      check("m_rd_req", 32'(m_rd_req), 32'(e_mrd));
      check("m_wr_req", 32'(m_wr_req), 32'(e_mwr));
      check("c0_rd_ack", 32'(c0_rd_ack), 32'(e_rack[0]));
      check("c0_wr_ack", 32'(c0_wr_ack), 32'(e_wack[0]));
      check("c1_rd_ack", 32'(c1_rd_ack), 32'(e_rack[1]));
      check("c1_wr_ack", 32'(c1_wr_ack), 32'(e_wack[1]));
      check("c0_d", 32'(c0_d), 32'(e_d[0]));
      check("c1_d", 32'(c1_d), 32'(e_d[1]));
   endtask

   task automatic ctrl_step();
      if (k_busy) begin
         if (k_cnt == 0) begin
            if (k_wr) m_wr_ack = ~m_wr_ack;
            else begin
               m_d = DW'($urandom);
               m_rd_ack = ~m_rd_ack;
            end
            k_busy = 0;
         end else k_cnt--;
      end else if (m_wr_req != m_wr_ack || m_rd_req != m_rd_ack) begin
         k_busy = 1;
         k_wr = (m_wr_req != m_wr_ack);
         k_cnt = int'($urandom_range(0, 7));
      end
   endtask

   task automatic client_step();
      for (int c = 0; c < 2; c++) begin
         if (c_rd_req[c] == e_rack[c] && c_wr_req[c] == e_wack[c]
             && $urandom_range(0, 2) == 0) begin
            int op;
            op = int'($urandom_range(0, 2));
            c_a[c] = {c[0], (AW-1)'($urandom)};
            c_q[c] = DW'($urandom);
            c_we[c] = (op != 0);
            if (op != 1) c_rd_req[c] = ~c_rd_req[c];
            if (op != 0) c_wr_req[c] = ~c_wr_req[c];
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      compare_all();
      if (auto_ctl) ctrl_step();
      if (auto_cli) client_step();
   endtask

   task automatic man_ack(input logic [DW-1:0] v);
      if (m_wr_req != m_wr_ack) m_wr_ack = m_wr_req;
      else begin
         m_d = v;
         m_rd_ack = m_rd_req;
      end
   endtask

   task automatic both_reads(input logic [AW:1] a0, input logic [AW:1] a1,
                             input bit c1_first, input string tag);
      c_a[0] = a0;
      c_a[1] = a1;
      c_we = 2'b00;
      c_rd_req = ~c_rd_req;
      tick();
      check({tag, "_first"}, 32'(m_a), c1_first ? 32'(a1) : 32'(a0));
      man_ack(16'h1111);
      tick();
      tick();
      check({tag, "_second"}, 32'(m_a), c1_first ? 32'(a0) : 32'(a1));
      man_ack(16'h2222);
      tick();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit c1_first_exp;
      c_a[0] = '0; c_a[1] = '0; c_q[0] = '0; c_q[1] = '0;
      c_we = '0; c_rd_req = '0; c_wr_req = '0;
      m_rd_ack = 1'b1; m_wr_ack = 1'b1; m_d = '0;
      auto_ctl = 0; auto_cli = 0; k_busy = 0; k_wr = 0; k_cnt = 0;
      r_done[0] = 0; r_done[1] = 0;
      model_reset();
      repeat (3) tick();
      reset_n = 1'b1;

      // stale controller acks: pending c0 write must not be issued
      c_a[0] = 16'h0123; c_q[0] = 16'hBEEF; c_we[0] = 1'b1;
      c_wr_req[0] = 1'b1;
      repeat (4) tick();
      check("sync_hold_wr", 32'(m_wr_req), 32'd0);
      check("sync_hold_rd", 32'(m_rd_req), 32'd0);
      m_rd_ack = 1'b0; m_wr_ack = 1'b0;
      tick();
      check("sync_to_idle_no_req", 32'(m_wr_req), 32'd0);
      tick();
      check("c0_wr_issue", 32'(m_wr_req), 32'd1);
      check("c0_wr_addr", 32'(m_a), 32'h0123);
      check("c0_wr_data", 32'(m_q), 32'hBEEF);
      check("c0_wr_we", 32'(m_we), 32'd1);
      tick();
      tick();
      m_wr_ack = 1'b1;
      check("c0_wr_ack_pending", 32'(c0_wr_ack), 32'd0);
      tick();
      check("c0_wr_ack_done", 32'(c0_wr_ack), 32'd1);
      check("c1_wr_ack_same", 32'(c1_wr_ack), 32'd0);
      check("c1_rd_ack_same", 32'(c1_rd_ack), 32'd0);

      // c1 read, one clock from pending to controller toggle
      c_a[1] = 16'h0123; c_we[1] = 1'b0; c_rd_req[1] = 1'b1;
      tick();
      check("c1_rd_issue", 32'(m_rd_req), 32'd1);
      check("c1_rd_we", 32'(m_we), 32'd0);
      check("c1_rd_addr", 32'(m_a), 32'h0123);
      m_d = 16'hBEEF; m_rd_ack = 1'b1;
      tick();
      check("c1_rd_data", 32'(c1_d), 32'hBEEF);
      check("c1_rd_ack_done", 32'(c1_rd_ack), 32'd1);
      check("c0_d_untouched", 32'(c0_d), 32'd0);

      // simultaneous reads, pointer at c0
      both_reads(16'h0010, 16'h8020, 1'b0, "rr0");
      // one c0 write moves the pointer to c1
      c_q[0] = 16'h5A5A; c_we[0] = 1'b1; c_wr_req[0] = ~c_wr_req[0];
      tick();
      man_ack('0);
      tick();
      tick();
`ifdef PORTTEST_ARB_FIXEDPRI_EN
      c1_first_exp = 1'b0;
`else
      c1_first_exp = 1'b1;
`endif
      both_reads(16'h0030, 16'h8040, c1_first_exp, "rr1");

      // random traffic
      r_done[0] = 0; r_done[1] = 0;
      auto_ctl = 1; auto_cli = 1;
      repeat (4000) tick();
      check("c0_progress", 32'(r_done[0] > 50), 32'd1);
`ifndef PORTTEST_ARB_FIXEDPRI_EN
      check("c1_progress", 32'(r_done[1] > 50), 32'd1);
`endif

      // reset while a transaction is outstanding
      auto_cli = 0;
      for (int i = 0; i < 100 && !r_busy; i++) tick();
      check("reached_wait", 32'(r_busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_m_rd_req", 32'(m_rd_req), 32'd0);
      check("rst_m_wr_req", 32'(m_wr_req), 32'd0);
      check("rst_m_a", 32'(m_a), 32'd0);
      check("rst_m_q", 32'(m_q), 32'd0);
      check("rst_m_we", 32'(m_we), 32'd0);
      check("rst_acks", 32'({c0_rd_ack, c0_wr_ack, c1_rd_ack, c1_wr_ack}), 32'd0);
      check("rst_d", 32'({c0_d, c1_d}), 32'd0);
      model_reset();
      c_rd_req = '0; c_wr_req = '0;
      repeat (2) tick();
      reset_n = 1'b1;
      auto_cli = 1;
      repeat (1500) tick();

      // drain
      auto_cli = 0;
      for (int i = 0; i < 200; i++) begin
         if (!r_busy && c_rd_req == e_rack && c_wr_req == e_wack) break;
         tick();
      end
      check("drained", 32'(!r_busy && c_rd_req == e_rack
                           && c_wr_req == e_wack), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
